// File: rtl/alif_spike_event_fifo.sv
// Timestamps rising edges of an ALIF spike train and queues them in a show-ahead FIFO.
// Optional spike-rate window counter is compiled in with `define SPIKE_RATE_EN.
module alif_spike_event_fifo #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4,
  parameter int WIN   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            spike_in,
  input  logic            clr,
  output logic [TS_W-1:0] evt_data,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic            overflow,
  output logic [7:0]      drop_cnt,
  output logic [7:0]      rate_out,
  output logic            rate_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  logic [TS_W-1:0] ts;
  logic            spike_q;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     occ;

  logic spike_edge;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Handshake: evt_valid is high whenever the FIFO holds an entry and does not
  // depend on evt_ready; a transfer happens on every rising edge where both are
  // high, and evt_data stays stable until that transfer.
  always_comb begin
    spike_edge = spike_in & ~spike_q & en;
    full       = (occ == OCC_FULL);
    pop        = evt_valid & evt_ready;
    push       = spike_edge & (~full | pop);
    drop       = spike_edge & full & ~pop;
  end

  assign evt_valid = (occ != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts      <= '0;
      spike_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
    end else begin
      spike_q <= spike_in;
      if (en)   ts     <= ts + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through occ.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ts;
  end

  // A drop in the same cycle as clr restarts the count at one rather than zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr)                    drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

`ifdef SPIKE_RATE_EN
  localparam int WC_W = (WIN > 1) ? $clog2(WIN) : 1;

  logic [WC_W-1:0] win_cnt;
  logic [7:0]      spike_cnt;
  logic [7:0]      spike_cnt_inc;
  logic            win_wrap;

  always_comb begin
    win_wrap      = en & (win_cnt == WC_W'(WIN-1));
    spike_cnt_inc = (push && spike_cnt != 8'hFF) ? spike_cnt + 8'd1 : spike_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt    <= '0;
      spike_cnt  <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= win_wrap;
      if (en) win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
      if (win_wrap) begin
        rate_out  <= spike_cnt_inc;
        spike_cnt <= '0;
      end else begin
        spike_cnt <= spike_cnt_inc;
      end
    end
  end
`else
  logic unused_win;
  assign unused_win = (WIN > 0);
  assign rate_out   = '0;
  assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_alif_spike_event_fifo.sv
// Bench for alif_spike_event_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed timestamp sequences.
module tb_alif_spike_event_fifo;

  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int WIN   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            spike_in;
  logic            clr;
  logic [TS_W-1:0] evt_data;
  logic            evt_valid;
  logic            evt_ready;
  logic            overflow;
  logic [7:0]      drop_cnt;
  logic [7:0]      rate_out;
  logic            rate_valid;

  alif_spike_event_fifo #(.TS_W(TS_W), .DEPTH(DEPTH), .WIN(WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .spike_in   (spike_in),
    .clr        (clr),
    .evt_data   (evt_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .rate_out   (rate_out),
    .rate_valid (rate_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // reference model state
  int               m_ts;
  bit               m_prev;
  logic [TS_W-1:0]  exp_q[$];
  int               m_drop;
  bit               m_ovf;
  int               m_win;
  int               m_sc;
  int               m_rate;
  bit               m_rv;

  logic [TS_W-1:0]  got_q[$];
  logic [TS_W-1:0]  exp_list[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit e;
    bit pushed;
    bit dropped;
    if (rst) begin
      m_ts = 0; m_prev = 0; exp_q.delete(); m_drop = 0; m_ovf = 0;
      m_win = 0; m_sc = 0; m_rate = 0; m_rv = 0;
    end else begin
      e       = spike_in && !m_prev && en;
      m_prev  = spike_in;
      pushed  = 0;
      dropped = 0;
      if (evt_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (e) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(TS_W'(m_ts));
          pushed = 1;
        end else begin
          dropped = 1;
        end
      end
      if (dropped) begin
        m_ovf  = 1;
        m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (clr) begin
        m_ovf  = 0;
        m_drop = 0;
      end
`ifdef SPIKE_RATE_EN
      m_rv = 0;
      if (pushed) m_sc = (m_sc < 255) ? m_sc + 1 : 255;
      if (en) begin
        if (m_win == WIN - 1) begin
          m_rate = m_sc;
          m_sc   = 0;
          m_rv   = 1;
          m_win  = 0;
        end else begin
          m_win++;
        end
      end
`endif
      if (en) m_ts = (m_ts + 1) % (1 << TS_W);
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("evt_valid", evt_valid, exp_q.size() != 0);
      chk("evt_data", evt_data, (exp_q.size() != 0) ? exp_q[0] : '0);
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      chk("rate_out", rate_out, m_rate);
      chk("rate_valid", rate_valid, m_rv);
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1; en = 1; spike_in = 0; clr = 0; evt_ready = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_ts(input int v);
    int n = 0;
    while (m_ts != v && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (m_ts != v) begin
      total++; bad++;
      $display("FAIL wait_ts: got %0d want %0d (timeout)", m_ts, v);
    end
  endtask

  task automatic pulse(input int v);
    wait_ts(v);
    spike_in = 1;
    @(negedge clk);
    spike_in = 0;
  endtask

  task automatic drain();
    got_q.delete();
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      if (!evt_valid) break;
      got_q.push_back(evt_data);
      evt_ready = 1;
      @(negedge clk);
    end
    evt_ready = 0;
  endtask

  task automatic check_list(input string name);
    chk({name, "_len"}, got_q.size(), exp_list.size());
    for (int i = 0; i < exp_list.size() && i < got_q.size(); i++)
      chk(name, got_q[i], exp_list[i]);
  endtask

  initial begin
    do_reset();
    chk_on = 1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_data", evt_data, 0);
    chk("rst_drop", drop_cnt, 0);

    // single pulse, one-cycle latency, single pop
    pulse(5);
    chk("t1_valid", evt_valid, 1);
    chk("t1_data", evt_data, 5);
    evt_ready = 1;
    @(negedge clk);
    evt_ready = 0;
    chk("t1_empty", evt_valid, 0);
    chk("t1_data0", evt_data, 0);

    // held level gives one event; re-arm after a low cycle
    do_reset();
    wait_ts(3);
    spike_in = 1;
    repeat (10) @(negedge clk);
    spike_in = 0;
    @(negedge clk);
    spike_in = 1;
    @(negedge clk);
    spike_in = 0;
    drain();
    exp_list = '{8'd3, 8'd14};
    check_list("t2_order");

    // overflow with six edges into a four-deep FIFO
    do_reset();
    for (int k = 2; k <= 12; k += 2) pulse(k);
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_cnt, 2);
    drain();
    exp_list = '{8'd2, 8'd4, 8'd6, 8'd8};
    check_list("t3_order");

    // full plus simultaneous pop accepts the push
    do_reset();
    for (int k = 2; k <= 8; k += 2) pulse(k);
    wait_ts(20);
    spike_in = 1; evt_ready = 1;
    @(negedge clk);
    spike_in = 0; evt_ready = 0;
    chk("t4_drop", drop_cnt, 0);
    chk("t4_ovf", overflow, 0);
    drain();
    exp_list = '{8'd4, 8'd6, 8'd8, 8'd20};
    check_list("t4_order");

    // timestamp wrap
    do_reset();
    pulse(255);
    @(negedge clk);
    pulse(0);
    drain();
    exp_list = '{8'd255, 8'd0};
    check_list("t5_wrap");

    // clr racing a drop, then a plain clr leaving contents alone
    do_reset();
    for (int k = 2; k <= 12; k += 2) pulse(k);
    wait_ts(14);
    spike_in = 1; clr = 1;
    @(negedge clk);
    spike_in = 0; clr = 0;
    chk("t5_clr_ovf", overflow, 1);
    chk("t5_clr_drop", drop_cnt, 1);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("t5_clr0_ovf", overflow, 0);
    chk("t5_clr0_drop", drop_cnt, 0);
    chk("t5_clr_keep", evt_valid, 1);
    drain();
    exp_list = '{8'd2, 8'd4, 8'd6, 8'd8};
    check_list("t5_clr_order");

    // en=0 freezes ts and blocks pushes but still drains
    do_reset();
    pulse(3);
    en = 0; spike_in = 1;
    @(negedge clk);
    spike_in = 0;
    @(negedge clk);
    en = 1; spike_in = 1;
    @(negedge clk);
    spike_in = 0;
    en = 0;
    drain();
    en = 1;
    exp_list = '{8'd3, 8'd4};
    check_list("t6_en");
    en = 0; spike_in = 1;
    @(negedge clk);
    en = 1;
    repeat (2) @(negedge clk);
    spike_in = 0;
    chk("t6_noedge", evt_valid, 0);

    // reset mid-operation discards entries
    do_reset();
    pulse(2);
    pulse(4);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t7_valid", evt_valid, 0);
    chk("t7_data", evt_data, 0);
    pulse(1);
    drain();
    exp_list = '{8'd1};
    check_list("t7_after");

    // rate window
    do_reset();
    pulse(2);
    pulse(5);
    pulse(9);
    drain();
    wait_ts(16);
`ifdef SPIKE_RATE_EN
    chk("t8_rate_valid", rate_valid, 1);
    chk("t8_rate_out", rate_out, 3);
`else
    chk("t8_rate_valid", rate_valid, 0);
    chk("t8_rate_out", rate_out, 0);
`endif
    @(negedge clk);
    chk("t8_rate_pulse", rate_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
